fp_mul_arbiter: RTL

Two-port arbiter and sequencer that shares one `FP_multiplier` instance between two requesters. It accepts an operand pair from either port over a valid/ready handshake, with round-robin priority. It pulses the multiplier's `start`, counts the multiplier's fixed latency, captures `product`/`overflow`, and returns them tagged with the requester id. One operation is in flight at a time. The block sits between the requesting logic and the multiplier and is the only driver of the multiplier's `start`, `fp1` and `fp2` inputs.

---
 rtl/fp_mul_arbiter_if.sv | 37 +++
 rtl/fp_mul_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter_if.sv
// Signal bundle linking two requesters, one result consumer and the shared
// multiplier to the arbiter; the arbiter takes the slave side.
`timescale 1ns/1ps
interface fp_mul_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_product;
    logic        rsp_overflow;
    logic        mul_start;
    logic [31:0] mul_fp1;
    logic [31:0] mul_fp2;
    logic [31:0] mul_product;
    logic        mul_overflow;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
               rsp_ready, mul_product, mul_overflow,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product,
               rsp_overflow, mul_start, mul_fp1, mul_fp2
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
               rsp_ready, mul_product, mul_overflow,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product,
               rsp_overflow, mul_start, mul_fp1, mul_fp2
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency FP multiplier
// between two requesters, one operation in flight at a time.
`timescale 1ns/1ps
module fp_mul_arbiter #(
    parameter int MUL_LATENCY = 4
) (
    input  logic            clk,
    input  logic            reset,
    fp_mul_arbiter_if.slave bus,
    output logic            busy
);
    localparam int CW = $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          last_grant;
    logic          armed;
    logic          grant0;
    logic          grant1;
    logic          start_r;
    logic [31:0]   fp1_r;
    logic [31:0]   fp2_r;
    logic          rsp_valid_r;
    logic          rsp_id_r;
    logic [31:0]   rsp_product_r;
    logic          rsp_overflow_r;
    logic          busy_r;

    // armed keeps grants off until the first clock edge after reset release.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && armed) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            last_grant     <= 1'b1;
            armed          <= 1'b0;
            start_r        <= 1'b0;
            fp1_r          <= '0;
            fp2_r          <= '0;
            rsp_valid_r    <= 1'b0;
            rsp_id_r       <= 1'b0;
            rsp_product_r  <= '0;
            rsp_overflow_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        fp1_r      <= grant1 ? bus.req1_a : bus.req0_a;
                        fp2_r      <= grant1 ? bus.req1_b : bus.req0_b;
                        rsp_id_r   <= grant1;
                        last_grant <= grant1;
                        start_r    <= 1'b1;
                        busy_r     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_r <= 1'b0;
                    count   <= CW'(MUL_LATENCY - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    // The multiplier result is valid on the edge where count reads zero.
                    if (count == '0) begin
                        rsp_product_r  <= bus.mul_product;
                        rsp_overflow_r <= bus.mul_overflow;
                        rsp_valid_r    <= 1'b1;
                        state          <= RESP;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready   = grant0;
    assign bus.req1_ready   = grant1;
    assign bus.mul_start    = start_r;
    assign bus.mul_fp1      = fp1_r;
    assign bus.mul_fp2      = fp2_r;
    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_id       = rsp_id_r;
    assign bus.rsp_product  = rsp_product_r;
    assign bus.rsp_overflow = rsp_overflow_r;
    assign busy             = busy_r;
endmodule
